// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: frame geometry, pixel/address widths and
// the capture state encoding used by reader, binarizer and capture writer.
package img_pkg;

    localparam int unsigned IMG_W        = 128;
    localparam int unsigned IMG_H        = 128;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned ADDR_W       = 14;
    localparam int unsigned FRAME_PIXELS = IMG_W * IMG_H;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/frame_ram_1w1r.sv
// Simple dual-port frame buffer: synchronous write, registered read with
// read-before-write on address collision; out-of-range reads return zero.
module frame_ram_1w1r #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DEPTH  = 16384
) (
    input  logic              i_clock,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    // Storage is deliberately not reset: stale image data survives a reset.
    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                r_rd_data <= (32'(i_rd_addr) < DEPTH) ? r_mem[i_rd_addr] : '0;
            end
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;

endmodule

// File: rtl/frame_capture_writer.sv
// Pixel-stream sink: writes incoming pixels into a raster frame buffer,
// counts completed frames and exposes a 1-cycle-latency readback port.
module frame_capture_writer #(
    parameter int unsigned IMG_W      = img_pkg::IMG_W,
    parameter int unsigned IMG_H      = img_pkg::IMG_H,
    parameter int unsigned DATA_W     = img_pkg::DATA_W,
    parameter int unsigned ADDR_W     = img_pkg::ADDR_W,
    parameter int unsigned NUM_FRAMES = 2
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sof,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        frame_cnt,
    output logic              frame_done,
    output logic              all_done,
    output logic              sof_err
);

    import img_pkg::*;

    localparam int unsigned       N_PIX     = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);
    localparam logic [7:0]        CNT_MAX   = 8'(NUM_FRAMES);

    state_t            r_state;
    state_t            w_next_state;
    logic              w_in_ready;
    logic              w_all_done;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] w_wr_idx;
    logic [7:0]        r_frame_cnt;
    logic              r_frame_done;
    logic              r_sof_err;
    logic              w_accept;
    logic              w_sof_cap;
    logic              w_frame_end;

    assign w_accept    = in_valid && w_in_ready;
    assign w_sof_cap   = sof && (r_state == CAPTURE);
    // A sof coinciding with a pixel places that pixel at address 0.
    assign w_wr_idx    = w_sof_cap ? '0 : r_wr_addr;
    assign w_frame_end = w_accept && (w_wr_idx == LAST_ADDR);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_all_done   = 1'b0;
        unique case (r_state)
            // Upstream may never issue sof, so IDLE always moves on.
            IDLE: w_next_state = CAPTURE;
            CAPTURE: begin
                w_in_ready = 1'b1;
                if (w_frame_end && (r_frame_cnt + 8'd1 == CNT_MAX)) begin
                    w_next_state = DONE;
                end
            end
            DONE: w_all_done = 1'b1;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr    <= '0;
            r_frame_cnt  <= '0;
            r_frame_done <= 1'b0;
            r_sof_err    <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_sof_cap && (r_wr_addr != '0)) begin
                r_sof_err <= 1'b1;
            end
            if (w_accept) begin
                r_wr_addr <= w_frame_end ? '0 : w_wr_idx + ADDR_W'(1);
            end else if (w_sof_cap) begin
                r_wr_addr <= '0;
            end
            if (w_frame_end && (r_frame_cnt != CNT_MAX)) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    frame_ram_1w1r #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (N_PIX)
    ) u_ram (
        .i_clock    (clock),
        .i_rst_n    (rst_n),
        .i_wr_en    (w_accept),
        .i_wr_addr  (w_wr_idx),
        .i_wr_data  (in_data),
        .i_rd_en    (rd_en),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (rd_data),
        .o_rd_valid (rd_valid)
    );

    assign in_ready   = w_in_ready;
    assign wr_addr    = r_wr_addr;
    assign frame_cnt  = r_frame_cnt;
    assign frame_done = r_frame_done;
    assign all_done   = w_all_done;
    assign sof_err    = r_sof_err;

endmodule

// File: tb/tb_frame_capture_writer.sv
// Self-checking bench for frame_capture_writer against a frame-level model
// (address/frame counters plus a shadow image array).
`timescale 1ns/1ps
module tb_frame_capture_writer;

    localparam int NPIX = 128 * 128;
    localparam int NFR  = 2;

    logic        clock = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        sof;
    logic        rd_en;
    logic [13:0] rd_addr;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [13:0] wr_addr;
    logic [7:0]  frame_cnt;
    logic        frame_done;
    logic        all_done;
    logic        sof_err;

    always #5 clock = ~clock;

    frame_capture_writer #(
        .IMG_W      (128),
        .IMG_H      (128),
        .DATA_W     (8),
        .ADDR_W     (14),
        .NUM_FRAMES (NFR)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sof        (sof),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .wr_addr    (wr_addr),
        .frame_cnt  (frame_cnt),
        .frame_done (frame_done),
        .all_done   (all_done),
        .sof_err    (sof_err)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_fd     = 0;

    // Reference model: frame position, completed frames, error flag, image.
    logic [7:0] ref_mem [NPIX];
    int         m_addr;
    int         m_cnt;
    int         m_pulses;
    bit         m_sof_err;

    always @(posedge clock) begin
        #1;
        if (frame_done === 1'b1) n_fd++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_addr    = 0;
        m_cnt     = 0;
        m_sof_err = 1'b0;
    endtask

    task automatic model_pixel(input logic [7:0] d, input bit s);
        if (m_cnt >= NFR) return;
        if (s) begin
            if (m_addr != 0) m_sof_err = 1'b1;
            m_addr = 0;
        end
        ref_mem[m_addr] = d;
        m_addr++;
        if (m_addr == NPIX) begin
            m_addr = 0;
            m_cnt++;
            m_pulses++;
        end
    endtask

    task automatic model_sof();
        if (m_cnt >= NFR) return;
        if (m_addr != 0) m_sof_err = 1'b1;
        m_addr = 0;
    endtask

    // Starts and ends on a falling edge; offers one pixel after 'gap' idle cycles.
    task automatic push(input logic [7:0] d, input bit s, input int gap);
        in_valid = 1'b0;
        sof      = 1'b0;
        repeat (gap) @(negedge clock);
        in_valid = 1'b1;
        in_data  = d;
        sof      = s;
        model_pixel(d, s);
        @(negedge clock);
        in_valid = 1'b0;
        sof      = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ":wr_addr"},    32'(wr_addr),    32'(m_addr));
        check({tag, ":frame_cnt"},  32'(frame_cnt),  32'(m_cnt));
        check({tag, ":all_done"},   32'(all_done),   32'(m_cnt >= NFR));
        check({tag, ":in_ready"},   32'(in_ready),   32'(m_cnt < NFR));
        check({tag, ":sof_err"},    32'(sof_err),    32'(m_sof_err));
        check({tag, ":done_count"}, 32'(n_fd),       32'(m_pulses));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":in_ready"},   32'(in_ready),   32'd0);
        check({tag, ":rd_data"},    32'(rd_data),    32'd0);
        check({tag, ":rd_valid"},   32'(rd_valid),   32'd0);
        check({tag, ":wr_addr"},    32'(wr_addr),    32'd0);
        check({tag, ":frame_cnt"},  32'(frame_cnt),  32'd0);
        check({tag, ":frame_done"}, 32'(frame_done), 32'd0);
        check({tag, ":all_done"},   32'(all_done),   32'd0);
        check({tag, ":sof_err"},    32'(sof_err),    32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        @(negedge clock);
        check_reset_outputs(tag);
        rst_n = 1'b1;
        model_reset();
        check({tag, ":ready_at_release"}, 32'(in_ready), 32'd0);
        @(negedge clock);
        check({tag, ":ready_after"}, 32'(in_ready), 32'd1);
    endtask

    task automatic rd_check(input string tag, input int a);
        logic [7:0] exp;
        exp     = ref_mem[a];
        rd_en   = 1'b1;
        rd_addr = 14'(a);
        @(negedge clock);
        check({tag, ":rd_valid"}, 32'(rd_valid), 32'd1);
        check({tag, ":rd_data"},  32'(rd_data),  32'(exp));
        rd_en = 1'b0;
        @(negedge clock);
        check({tag, ":rd_valid_drop"}, 32'(rd_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] old_val;
        logic [7:0] d;
        int         gap;
        int         bad;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        sof      = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        m_pulses = 0;
        model_reset();
        @(negedge clock);
        do_reset("por");

        // Frame 1 at one pixel per two clocks, data = addr mod 256.
        for (int i = 0; i < NPIX; i++) push(8'(i), 1'b0, 1);
        check("f1:frame_done_pulse", 32'(frame_done), 32'd1);
        check_model("f1");
        @(negedge clock);
        check("f1:frame_done_clear", 32'(frame_done), 32'd0);
        rd_check("rd300", 300);
        check("rd300:literal", 32'(ref_mem[300]), 32'h2C);
        rd_check("rd_last_f1", NPIX - 1);

        // Frame 2 back-to-back, data = ~addr; reaches all_done.
        for (int i = 0; i < NPIX; i++) push(~8'(i), 1'b0, 0);
        check_model("f2");
        push(8'h11, 1'b0, 0);
        push(8'h22, 1'b1, 0);
        check_model("done_ignore");
        rd_check("rd0_done", 0);

        // Mid-frame asynchronous reset at wr_addr = 8000.
        do_reset("r2");
        for (int i = 0; i < 8000; i++) push(8'($urandom), 1'b0, 0);
        check_model("pre_async");
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        model_reset();
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        check("async:ready_after", 32'(in_ready), 32'd1);

        // sof with a pixel at address 0 is legal; then a partial frame and a mid-frame sof.
        push(8'd0, 1'b1, 0);
        check("sof_at_zero:sof_err", 32'(sof_err), 32'd0);
        check("sof_at_zero:wr_addr", 32'(wr_addr), 32'd1);
        for (int i = 1; i < 100; i++) push(8'(i), 1'b0, 0);
        sof = 1'b1;
        model_sof();
        @(negedge clock);
        sof = 1'b0;
        check_model("sof_mid");

        // Full frame with random gaps and a read/write collision at address 5.
        for (int i = 0; i < NPIX; i++) begin
            gap = 0;
            if (i != 5 && i != 6 && $urandom_range(0, 15) == 0) gap = $urandom_range(1, 5);
            d = (i == 5) ? 8'hAA : 8'($urandom);
            if (i == 5) begin
                old_val = ref_mem[5];
                rd_en   = 1'b1;
                rd_addr = 14'd5;
            end
            push(d, 1'b0, gap);
            if (i == 5) begin
                check("rbw:old_data", 32'(rd_data), 32'(old_val));
                check("rbw:old_literal", 32'(old_val), 32'h05);
            end
            if (i == 6) begin
                check("rbw:new_data", 32'(rd_data), 32'hAA);
                check("rbw:valid", 32'(rd_valid), 32'd1);
                rd_en = 1'b0;
            end
        end
        check_model("rand_frame");

        // Pipelined readback of the whole buffer against the shadow image.
        bad   = 0;
        rd_en = 1'b1;
        for (int a = 0; a < NPIX; a++) begin
            rd_addr = 14'(a);
            @(negedge clock);
            if (rd_valid !== 1'b1 || rd_data !== ref_mem[a]) bad++;
        end
        rd_en = 1'b0;
        check("scoreboard:mismatches", 32'(bad), 32'd0);
        @(negedge clock);
        check("scoreboard:valid_drop", 32'(rd_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
